apb_master_ctrl: RTL and testbench



---
 rtl/usrt_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 33 +++
 rtl/apb_master_ctrl.sv | 121 ++++++++++++
 tb/tb_apb_master_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared definitions for the APB link into the USRT peripheral.
// Holds the master FSM state encoding and the default bus widths used on both sides.
package usrt_pkg;

    localparam int USRT_ADDR_W = 33;
    localparam int USRT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apbState_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter with a timeout flag.
// Latency: timeout is combinational, valid in the cycle that would be the TIMEOUT-th wait.
// Backpressure: none; clr has priority over en, and timeout is tied low when TIMEOUT = 0.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pClk,
    input  logic pReset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] SAT_VAL  = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST_VAL = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] waitCnt;

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            waitCnt <= '0;
        end else if (clr) begin
            waitCnt <= '0;
        end else if (en && (waitCnt != SAT_VAL)) begin
            waitCnt <= waitCnt + CW'(1);
        end
    end

    // en marks a wait cycle in progress, so this cycle is the TIMEOUT-th one
    assign timeout = (TIMEOUT > 0) && en && (waitCnt >= LAST_VAL);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: single valid/ready command in, SETUP/ACCESS sequence out, one response back.
// Latency: 3 cycles accept-to-rsp_valid with no wait states, +1 per wait state.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle strobe with no backpressure.
module apb_master_ctrl
    import usrt_pkg::*;
#(
    parameter int ADDR_W  = USRT_ADDR_W,
    parameter int DATA_W  = USRT_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pSelect,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddress,
    output logic [DATA_W-1:0] pWData,
    input  logic [DATA_W-1:0] pRData,
    input  logic              pReady
);

    apbState_t state;
    apbState_t nextState;
    logic      accept;
    logic      done;
    logic      abort;
    logic      waitEn;
    logic      timeout;

    assign cmd_ready = (state == IDLE);
    assign waitEn    = (state == ACCESS) && !pReady;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pClk    (pClk),
        .pReset  (pReset),
        .clr     (accept),
        .en      (waitEn),
        .timeout (timeout)
    );

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // pReady is tested before timeout so a late ready still completes cleanly
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    nextState = SETUP;
                end
            end
            SETUP: nextState = ACCESS;
            ACCESS: begin
                if (pReady) begin
                    done      = 1'b1;
                    nextState = IDLE;
                end else if (timeout) begin
                    abort     = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // The APB output registers double as the command latch.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            pSelect   <= 1'b0;
            pEnable   <= 1'b0;
            pWrite    <= 1'b0;
            pAddress  <= '0;
            pWData    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                pSelect  <= 1'b1;
                pWrite   <= cmd_write;
                pAddress <= cmd_addr;
                pWData   <= cmd_write ? cmd_wdata : '0;
            end
            if (state == SETUP) begin
                pEnable <= 1'b1;
            end
            if (done || abort) begin
                pSelect   <= 1'b0;
                pEnable   <= 1'b0;
                pWrite    <= 1'b0;
                pAddress  <= '0;
                pWData    <= '0;
                rsp_valid <= 1'b1;
                rsp_err   <= abort;
                rsp_rdata <= (done && !pWrite) ? pRData : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: writes, wait states, timeout, back-to-back and reset abort.
module tb_apb_master_ctrl;

    localparam int ADDR_W  = 33;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              pClk;
    logic              pReset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              pSelect;
    logic              pEnable;
    logic              pWrite;
    logic [ADDR_W-1:0] pAddress;
    logic [DATA_W-1:0] pWData;
    logic [DATA_W-1:0] pRData;
    logic              pReady;

    int checks   = 0;
    int failures = 0;

    apb_master_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pClk      (pClk),
        .pReset    (pReset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pSelect   (pSelect),
        .pEnable   (pEnable),
        .pWrite    (pWrite),
        .pAddress  (pAddress),
        .pWData    (pWData),
        .pRData    (pRData),
        .pReady    (pReady)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        pReset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pRData    = '0;
        pReady    = 1'b1;

        // Reset state
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pSelect", pSelect, 0);
        check("rst_pEnable", pEnable, 0);
        check("rst_pAddress", pAddress, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        #2 pReset = 1'b1;
        tick();

        // Zero-wait write 0xA5 -> 0x4
        issue(1'b1, 33'h4, 8'hA5);
        check("w1_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("w1_setup_sel", pSelect, 1);
        check("w1_setup_en", pEnable, 0);
        check("w1_setup_wr", pWrite, 1);
        check("w1_setup_addr", pAddress, 33'h4);
        check("w1_setup_wdata", pWData, 8'hA5);
        check("w1_busy_ready", cmd_ready, 0);
        tick();
        check("w1_access_sel", pSelect, 1);
        check("w1_access_en", pEnable, 1);
        check("w1_access_addr", pAddress, 33'h4);
        check("w1_access_wdata", pWData, 8'hA5);
        check("w1_access_rsp", rsp_valid, 0);
        tick();
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp_err", rsp_err, 0);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_end_sel", pSelect, 0);
        check("w1_end_en", pEnable, 0);
        check("w1_end_addr", pAddress, 0);
        check("w1_end_wdata", pWData, 0);
        tick();
        check("w1_rsp_pulse", rsp_valid, 0);

        // Read 0x8 with two wait states, wdata must not leak onto pWData
        pReady = 1'b0;
        issue(1'b0, 33'h8, 8'hFF);
        tick();
        cmd_valid = 1'b0;
        check("r2_setup_wdata", pWData, 0);
        check("r2_setup_wr", pWrite, 0);
        tick();
        check("r2_acc1_en", pEnable, 1);
        check("r2_acc1_addr", pAddress, 33'h8);
        tick();
        check("r2_acc2_addr", pAddress, 33'h8);
        check("r2_acc2_sel", pSelect, 1);
        check("r2_acc2_rsp", rsp_valid, 0);
        tick();
        check("r2_acc3_en", pEnable, 1);
        check("r2_acc3_rsp", rsp_valid, 0);
        pReady = 1'b1;
        pRData = 8'h3C;
        tick();
        check("r2_rsp_valid", rsp_valid, 1);
        check("r2_rsp_rdata", rsp_rdata, 8'h3C);
        check("r2_rsp_err", rsp_err, 0);
        pRData = 8'h00;
        tick();
        check("r2_hold_rdata", rsp_rdata, 8'h3C);

        // Timeout: pReady never rises, abort after 16 ACCESS cycles
        pReady = 1'b0;
        pRData = 8'h77;
        issue(1'b0, 33'h10, 8'h00);
        tick();
        cmd_valid = 1'b0;
        repeat (16) tick();
        check("to_last_sel", pSelect, 1);
        check("to_last_rsp", rsp_valid, 0);
        tick();
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_end_sel", pSelect, 0);
        check("to_end_ready", cmd_ready, 1);
        tick();

        // pReady rises on the 16th wait cycle: normal completion
        pRData = 8'h5A;
        issue(1'b0, 33'h20, 8'h00);
        tick();
        cmd_valid = 1'b0;
        repeat (16) tick();
        check("late_acc16_sel", pSelect, 1);
        check("late_acc16_rsp", rsp_valid, 0);
        pReady = 1'b1;
        tick();
        check("late_rsp_valid", rsp_valid, 1);
        check("late_rsp_err", rsp_err, 0);
        check("late_rsp_rdata", rsp_rdata, 8'h5A);
        tick();

        // Back-to-back, cmd_valid held high across both commands
        issue(1'b1, 33'h30, 8'h11);
        tick();
        issue(1'b1, 33'h31, 8'h22);
        check("b2b_a_addr", pAddress, 33'h30);
        tick();
        check("b2b_held_off", cmd_ready, 0);
        check("b2b_a_access_addr", pAddress, 33'h30);
        check("b2b_a_access_wdata", pWData, 8'h11);
        tick();
        check("b2b_a_rsp", rsp_valid, 1);
        check("b2b_gap_sel", pSelect, 0);
        check("b2b_gap_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_b_sel", pSelect, 1);
        check("b2b_b_addr", pAddress, 33'h31);
        check("b2b_b_wdata", pWData, 8'h22);
        check("b2b_b_rsp_low", rsp_valid, 0);
        tick();
        check("b2b_b_en", pEnable, 1);
        tick();
        check("b2b_b_rsp", rsp_valid, 1);
        check("b2b_b_err", rsp_err, 0);
        tick();

        // Reset during ACCESS of a read
        pReady = 1'b0;
        issue(1'b0, 33'h40, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rr_access_en", pEnable, 1);
        #2 pReset = 1'b0;
        #1;
        check("rr_async_sel", pSelect, 0);
        check("rr_async_en", pEnable, 0);
        check("rr_async_addr", pAddress, 0);
        check("rr_async_ready", cmd_ready, 1);
        tick();
        check("rr_no_rsp_a", rsp_valid, 0);
        #2 pReset = 1'b1;
        tick();
        check("rr_no_rsp_b", rsp_valid, 0);
        check("rr_ready_after", cmd_ready, 1);
        pReady = 1'b1;
        issue(1'b1, 33'h44, 8'h9C);
        tick();
        cmd_valid = 1'b0;
        check("rr_w_addr", pAddress, 33'h44);
        check("rr_w_wdata", pWData, 8'h9C);
        tick();
        check("rr_w_en", pEnable, 1);
        tick();
        check("rr_w_rsp", rsp_valid, 1);
        check("rr_w_err", rsp_err, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
